// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin arbiter and single-byte transaction
// sequencer sharing one I2C master between NUM_REQ requesters.
// Grants the next requester after the previous owner, launches its
// command when the master is free, watches for completion with a
// watchdog and returns read data / error status to the owner.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_rdata,
    output logic [1:0]             rsp_err,
    output logic                   m_start_txn,
    output logic                   m_rw,
    output logic [6:0]             m_sub_addr,
    output logic [7:0]             m_data_in,
    output logic                   m_data_valid,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_ack_error,
    input  logic [7:0]             m_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     sel_r;
    logic [IDX_W-1:0]     last_grant_r;
    logic [IDX_W-1:0]     pick_s;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [NUM_REQ-1:0]   rsp_valid_r;
    logic [7:0]           rsp_rdata_r;
    logic [1:0]           rsp_err_r;
    logic                 m_rw_r;
    logic [6:0]           m_sub_addr_r;
    logic [7:0]           m_data_in_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 any_req_s;
    logic                 timeout_s;
    logic                 launch_s;
    logic                 pick_rw_s;
    logic [6:0]           pick_addr_s;
    logic [7:0]           pick_wdata_s;
    logic [NUM_REQ-1:0]   pick_onehot_s;
    logic [NUM_REQ-1:0]   sel_onehot_s;

    // First requester found scanning upward from the one after the last owner.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && r[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Arbitration choice and the request fields belonging to it.
    always_comb begin
        any_req_s     = |req;
        pick_s        = rr_pick(req, last_grant_r);
        pick_rw_s     = req_rw[pick_s];
        pick_addr_s   = req_addr[int'(pick_s)*7 +: 7];
        pick_wdata_s  = req_wdata[int'(pick_s)*8 +: 8];
        pick_onehot_s = ONE_HOT0 << pick_s;
        sel_onehot_s  = ONE_HOT0 << sel_r;
        timeout_s     = (cnt_r == CNT_LAST);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the single-cycle launch strobes; the launch has to
    // follow the live m_busy so the command goes out in the very cycle the
    // master frees up.
    always_comb begin
        state_nxt_s  = state_r;
        launch_s     = 1'b0;
        m_start_txn  = 1'b0;
        m_data_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (!m_busy) begin
                    launch_s     = 1'b1;
                    m_start_txn  = 1'b1;
                    m_data_valid = !m_rw_r;
                    state_nxt_s  = ST_WAIT;
                end else begin
                    state_nxt_s = ST_LAUNCH;
                end
            end
            ST_WAIT: begin
                if (m_done || timeout_s) begin
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Grant, command fields, watchdog counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r        <= '0;
            last_grant_r <= LAST_RST;
            gnt_r        <= '0;
            rsp_valid_r  <= '0;
            rsp_rdata_r  <= 8'h00;
            rsp_err_r    <= 2'b00;
            m_rw_r       <= 1'b0;
            m_sub_addr_r <= 7'h00;
            m_data_in_r  <= 8'h00;
            cnt_r        <= '0;
        end else begin
            rsp_valid_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        sel_r        <= pick_s;
                        gnt_r        <= pick_onehot_s;
                        m_rw_r       <= pick_rw_s;
                        m_sub_addr_r <= pick_addr_s;
                        m_data_in_r  <= pick_wdata_s;
                    end else begin
                        gnt_r <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (launch_s) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        // Completion takes priority over a coincident timeout.
                        rsp_rdata_r <= m_rw_r ? m_data_out : 8'h00;
                        rsp_err_r   <= {1'b0, m_ack_error};
                        rsp_valid_r <= sel_onehot_s;
                    end else if (timeout_s) begin
                        rsp_rdata_r <= 8'h00;
                        rsp_err_r   <= 2'b10;
                        rsp_valid_r <= sel_onehot_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    last_grant_r <= sel_r;
                    gnt_r        <= '0;
                end
                default: begin
                    gnt_r <= '0;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign m_rw       = m_rw_r;
    assign m_sub_addr = m_sub_addr_r;
    assign m_data_in  = m_data_in_r;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: transaction-level reference
// model (round-robin owner, expected response data/status and response
// cycle) driving a behavioural I2C master with randomized timing.
module tb_i2c_master_arbiter;

    localparam int N = 2;
    localparam int T = 16;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req;
    logic [1:0]   req_rw;
    logic [13:0]  req_addr;
    logic [15:0]  req_wdata;
    logic [1:0]   gnt;
    logic [1:0]   rsp_valid;
    logic [7:0]   rsp_rdata;
    logic [1:0]   rsp_err;
    logic         m_start_txn;
    logic         m_rw;
    logic [6:0]   m_sub_addr;
    logic [7:0]   m_data_in;
    logic         m_data_valid;
    logic         m_busy;
    logic         m_done;
    logic         m_ack_error;
    logic [7:0]   m_data_out;

    int n_checks;
    int n_errors;
    int last_grant_m;
    logic [6:0] addr_tab [N];
    logic [7:0] data_tab [N];
    logic       rw_tab   [N];

    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_start_txn(m_start_txn), .m_rw(m_rw), .m_sub_addr(m_sub_addr),
        .m_data_in(m_data_in), .m_data_valid(m_data_valid), .m_busy(m_busy),
        .m_done(m_done), .m_ack_error(m_ack_error), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Round-robin rule: first requester at or after last owner + 1.
    function automatic int rr_pick_m(input logic [1:0] pat);
        for (int k = 1; k <= N; k++) begin
            if (pat[(last_grant_m + k) % N]) return (last_grant_m + k) % N;
        end
        return last_grant_m;
    endfunction

    task automatic drive_fields();
        req_addr  = {addr_tab[1], addr_tab[0]};
        req_wdata = {data_tab[1], data_tab[0]};
        req_rw    = {rw_tab[1], rw_tab[0]};
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_gnt"},       32'(gnt),          32'(0));
        check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid),    32'(0));
        check_eq({pfx, "_rsp_rdata"}, 32'(rsp_rdata),    32'(0));
        check_eq({pfx, "_rsp_err"},   32'(rsp_err),      32'(0));
        check_eq({pfx, "_start"},     32'(m_start_txn),  32'(0));
        check_eq({pfx, "_m_rw"},      32'(m_rw),         32'(0));
        check_eq({pfx, "_sub_addr"},  32'(m_sub_addr),   32'(0));
        check_eq({pfx, "_data_in"},   32'(m_data_in),    32'(0));
        check_eq({pfx, "_dvalid"},    32'(m_data_valid), 32'(0));
    endtask

    // One full transaction, entered and left in an IDLE cycle (edge + 2).
    // done_d: cycles after the start pulse at which the master finishes;
    // any value above T means the master never answers.
    task automatic run_txn(input logic [1:0] pat, input int busy_n, input int done_d,
                           input logic nack, input logic [7:0] mdata, input bit disturb);
        int         w;
        int         resp_at;
        logic [1:0] oh;
        logic [6:0] ea;
        logic [7:0] ed;
        logic       erw;
        logic [1:0] e_err;
        logic [7:0] e_rd;
        w   = rr_pick_m(pat);
        oh  = 2'(1) << w;
        ea  = addr_tab[w];
        ed  = data_tab[w];
        erw = rw_tab[w];
        resp_at = (done_d <= T) ? done_d + 1 : T + 1;
        e_err   = (done_d <= T) ? {1'b0, nack} : 2'b10;
        e_rd    = (done_d <= T && erw) ? mdata : 8'h00;
        drive_fields();
        req    = pat;
        m_done = 1'b0;
        m_busy = 1'b0;
        @(posedge clk); #1;
        if (disturb) begin
            req[w]    = 1'b0;
            req_addr  = 14'($urandom);
            req_wdata = 16'($urandom);
            req_rw    = 2'($urandom);
        end
        for (int b = 0; b < busy_n; b++) begin
            m_busy = 1'b1;
            m_done = 1'($urandom);
            #1;
            check_eq("hold_start", 32'(m_start_txn), 32'(0));
            check_eq("hold_gnt",   32'(gnt),         32'(oh));
            @(posedge clk); #1;
        end
        m_busy = 1'b0;
        m_done = 1'b0;
        #1;
        check_eq("launch_start",  32'(m_start_txn),  32'(1));
        check_eq("launch_dvalid", 32'(m_data_valid), 32'(!erw));
        check_eq("launch_gnt",    32'(gnt),          32'(oh));
        check_eq("launch_addr",   32'(m_sub_addr),   32'(ea));
        check_eq("launch_wdata",  32'(m_data_in),    32'(ed));
        check_eq("launch_rw",     32'(m_rw),         32'(erw));
        for (int j = 1; j < resp_at; j++) begin
            @(posedge clk); #1;
            m_busy      = 1'b1;
            m_done      = (j == done_d);
            m_ack_error = (j == done_d) ? nack : 1'($urandom);
            m_data_out  = (j == done_d) ? mdata : 8'($urandom);
            #1;
            check_eq("wait_rsp_valid", 32'(rsp_valid),    32'(0));
            check_eq("wait_start",     32'(m_start_txn),  32'(0));
            check_eq("wait_dvalid",    32'(m_data_valid), 32'(0));
            check_eq("wait_gnt",       32'(gnt),          32'(oh));
        end
        @(posedge clk); #1;
        m_busy      = 1'b0;
        m_done      = 1'b0;
        m_ack_error = 1'b0;
        req[w]      = 1'b0;
        #1;
        check_eq("rsp_valid", 32'(rsp_valid), 32'(oh));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
        check_eq("rsp_err",   32'(rsp_err),   32'(e_err));
        check_eq("rsp_gnt",   32'(gnt),       32'(oh));
        last_grant_m = w;
        @(posedge clk); #2;
        check_eq("idle_gnt",       32'(gnt),       32'(0));
        check_eq("idle_rsp_valid", 32'(rsp_valid), 32'(0));
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            addr_tab[i] = 7'($urandom);
            data_tab[i] = 8'($urandom);
            rw_tab[i]   = 1'($urandom);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        last_grant_m = N - 1;
        clk          = 1'b0;
        rst_n        = 1'b0;
        req          = 2'b00;
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_ack_error  = 1'b0;
        m_data_out   = 8'h00;
        randomize_fields();
        drive_fields();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        // Single write from requester 0.
        addr_tab[0] = 7'h50; data_tab[0] = 8'hA5; rw_tab[0] = 1'b0;
        run_txn(2'b01, 0, 12, 1'b0, 8'h99, 1'b0);

        // Read from requester 1.
        addr_tab[1] = 7'h3C; rw_tab[1] = 1'b1;
        run_txn(2'b10, 0, 9, 1'b0, 8'h7E, 1'b0);

        // Both requesting continuously: ownership alternates 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            randomize_fields();
            run_txn(2'b11, 0, 3 + k, 1'b0, 8'($urandom), 1'b0);
            check_eq("alternate_owner", 32'(last_grant_m), 32'(k % 2));
        end

        // NACK.
        randomize_fields();
        rw_tab[0] = 1'b0;
        run_txn(2'b01, 0, 5, 1'b1, 8'h00, 1'b0);

        // Watchdog timeout, then a late m_done must be ignored.
        randomize_fields();
        rw_tab[1] = 1'b1;
        run_txn(2'b10, 0, 1000, 1'b0, 8'h55, 1'b0);
        req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            m_done = (k == 0);
            #1;
            check_eq("late_done_rsp", 32'(rsp_valid), 32'(0));
            check_eq("late_done_gnt", 32'(gnt),       32'(0));
            @(posedge clk); #2;
        end
        m_done = 1'b0;

        // Master busy at grant; fields changed and req dropped after grant.
        randomize_fields();
        run_txn(2'b11, 5, 4, 1'b0, 8'h3A, 1'b1);

        // Done exactly at the timeout threshold, and one cycle after it.
        randomize_fields();
        run_txn(2'b11, 0, T, 1'b1, 8'hC3, 1'b0);
        randomize_fields();
        run_txn(2'b11, 0, T + 1, 1'b0, 8'hC3, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            randomize_fields();
            run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(1, 20),
                    1'($urandom), 8'($urandom), 1'($urandom));
        end

        // Reset in the middle of WAIT_DONE.
        randomize_fields();
        run_txn(2'b01, 0, 2, 1'b0, 8'h11, 1'b0);
        randomize_fields();
        drive_fields();
        req = 2'b01;
        @(posedge clk); #2;
        check_eq("pre_reset_start", 32'(m_start_txn), 32'(1));
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b0;
        req   = 2'b00;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            m_done = 1'($urandom);
            #1;
            check_eq("post_reset_rsp", 32'(rsp_valid), 32'(0));
            check_eq("post_reset_gnt", 32'(gnt),       32'(0));
            @(posedge clk); #2;
        end
        m_done = 1'b0;
        last_grant_m = N - 1;
        randomize_fields();
        run_txn(2'b11, 0, 6, 1'b0, 8'h42, 1'b0);
        check_eq("post_reset_owner", 32'(last_grant_m), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
